uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of queued direction commands (power of two, 2..16).
REQ-002 Parameter UPPER_EN, default 1, SHALL make uppercase ASCII equivalent to lowercase when set.
REQ-003 clk  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 rx_wr  input  1  one-cycle strobe; rx_data is valid when it is 1.
REQ-007 dir  output  2  head direction: 00 up, 01 right, 10 down, 11 left.
REQ-008 dir_valid  output  1  dir holds an unconsumed command.
REQ-009 dir_ready  input  1  consumer (snake game tick) accepts dir.
REQ-010 paused  output  1  game pause state.
REQ-011 restart  output  1  one-cycle restart pulse.
REQ-012 err_count  output  8  saturating count of rejected bytes.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued commands.

Function
REQ-014 Decode on the rx_wr cycle: 'w' 0x77 up; 'd' 0x64 right; 's' 0x73 down; 'a' 0x61 left; 'p' 0x70 toggle pause; 'r' 0x72 restart; with UPPER_EN, 0x57/0x44/0x53/0x41/0x50/0x52 also apply.
REQ-015 Any other byte SHALL increment err_count and change nothing else.
REQ-016 last_dir register SHALL hold the most recently enqueued direction (right after reset/restart).
REQ-017 A direction equal to last_dir SHALL be dropped silently.
REQ-018 A direction equal to last_dir XOR 2'b10 (reversal) SHALL be dropped and SHALL increment err_count.
REQ-019 A direction arriving while paused=1 SHALL be dropped silently.
REQ-020 Otherwise, the direction SHALL be enqueued and last_dir updated in the same edge.
REQ-021 Enqueue when full with no pop the same cycle SHALL drop the byte and increment err_count; last_dir unchanged.
REQ-022 Enqueue when full with a pop (dir_valid & dir_ready) the same cycle SHALL be accepted; fifo_level unchanged.
REQ-023 Latency: a byte enqueued into an empty FIFO at edge N SHALL give dir_valid=1 and the new dir after edge N.
REQ-024 Pop occurs on dir_valid & dir_ready; dir and dir_valid SHALL remain stable while dir_valid=1 and dir_ready=0.
REQ-025 When the FIFO is empty, dir SHALL hold the last popped value and dir_valid SHALL be 0.
REQ-026 paused=1 SHALL force dir_valid=0 with no pops; queued entries are retained and presented again after unpause.
REQ-027 'r' SHALL flush the FIFO, clear paused, and set last_dir to right; restart SHALL be 1 for exactly the cycle after the rx_wr cycle.
REQ-028 err_count SHALL saturate at 255.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While rst=1 at an edge: dir=01, dir_valid=0, paused=0, restart=0, err_count=0, fifo_level=0, last_dir=01, pointers=0.
REQ-031 Reset mid-operation SHALL discard queued entries and any rx_wr in that cycle.

Structure
REQ-032 Package snake_pkg SHALL hold the direction encodings (DIR_UP/RIGHT/DOWN/LEFT) and the ASCII command constants; the snake block uses the same package.
REQ-033 Queueing SHALL be one sub-module, cmd_fifo: a synchronous FIFO of 2-bit entries with push, pop, full, empty, and level.

Verification
REQ-034 Reset, then 'w' with dir_ready=0 -> dir_valid=1, dir=00, fifo_level=1 one cycle later.
REQ-035 After reset, 'a' -> dropped, err_count=1 (reversal of right); then 'd' -> dropped silently, err_count stays 1.
REQ-036 FIFO_DEPTH=4, ready=0, send w,d,s,d,w -> fifo_level=4 after the 4th; the 5th is dropped, err_count=1; with ready=1 the pops give 00,01,10,01.
REQ-037 Full FIFO, a byte and a pop on the same cycle -> byte accepted, fifo_level stays 4.
REQ-038 Queue 2 entries, send 'p' -> dir_valid=0; 's' is ignored; a second 'p' -> dir_valid=1, original head presented.
REQ-039 Queue 3 entries, send 'r' -> next cycle restart=1, fifo_level=0, paused=0; 0xFF 300 times -> err_count=255.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: head directions and ASCII command bytes.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam logic [7:0] CMD_UP      = 8'h77;
  localparam logic [7:0] CMD_RIGHT   = 8'h64;
  localparam logic [7:0] CMD_DOWN    = 8'h73;
  localparam logic [7:0] CMD_LEFT    = 8'h61;
  localparam logic [7:0] CMD_PAUSE   = 8'h70;
  localparam logic [7:0] CMD_RESTART = 8'h72;

  // Folds 'A'..'Z' onto 'a'..'z'; every other byte passes through unchanged.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of 2-bit direction entries with flush, full/empty and level.
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [1:0]               wdata_i,
  output logic [1:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && ((level_q != FULL_LVL) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Turns UART command bytes into a queue of snake head directions plus pause/restart control.
module uart_cmd_decoder
  import snake_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit UPPER_EN   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_wr,
  output logic [1:0]                    dir,
  output logic                          dir_valid,
  input  logic                          dir_ready,
  output logic                          paused,
  output logic                          restart,
  output logic [7:0]                    err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  logic [7:0] cmd_byte;
  logic [1:0] cmd_dir, head, last_dir_q, last_pop_q;
  logic       is_dir, is_pause, is_restart, is_bad;
  logic       paused_q, restart_q, full, empty;
  logic       pop, dir_ok, reversal, push, overflow, err_inc;
  logic [7:0] err_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    cmd_byte   = UPPER_EN ? fold_case(rx_data) : rx_data;
    is_dir     = 1'b0;
    is_pause   = 1'b0;
    is_restart = 1'b0;
    is_bad     = 1'b0;
    cmd_dir    = DIR_UP;
    if (rx_wr) begin
      case (cmd_byte)
        CMD_UP:      begin is_dir = 1'b1; cmd_dir = DIR_UP;    end
        CMD_RIGHT:   begin is_dir = 1'b1; cmd_dir = DIR_RIGHT; end
        CMD_DOWN:    begin is_dir = 1'b1; cmd_dir = DIR_DOWN;  end
        CMD_LEFT:    begin is_dir = 1'b1; cmd_dir = DIR_LEFT;  end
        CMD_PAUSE:   is_pause   = 1'b1;
        CMD_RESTART: is_restart = 1'b1;
        default:     is_bad     = 1'b1;
      endcase
    end
  end

  // Paused drops are silent and take precedence over the reversal check.
  assign pop      = dir_valid && dir_ready;
  assign dir_ok   = is_dir && !paused_q && (cmd_dir != last_dir_q) &&
                    (cmd_dir != (last_dir_q ^ 2'b10));
  assign reversal = is_dir && !paused_q && (cmd_dir == (last_dir_q ^ 2'b10));
  assign push     = dir_ok && (!full || pop);
  assign overflow = dir_ok && full && !pop;
  assign err_inc  = is_bad || reversal || overflow;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (is_restart),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cmd_dir),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      paused_q   <= 1'b0;
      restart_q  <= 1'b0;
      err_q      <= '0;
      last_dir_q <= DIR_RIGHT;
      last_pop_q <= DIR_RIGHT;
    end else begin
      restart_q <= is_restart;
      if (err_inc) err_q <= sat_inc(err_q);
      if (is_restart) begin
        paused_q   <= 1'b0;
        last_dir_q <= DIR_RIGHT;
      end else begin
        if (is_pause) paused_q   <= ~paused_q;
        if (push)     last_dir_q <= cmd_dir;
      end
      if (pop) last_pop_q <= head;
    end
  end

  // With nothing queued the consumer keeps seeing the last direction it took.
  assign dir       = empty ? last_pop_q : head;
  assign dir_valid = !empty && !paused_q;
  assign paused    = paused_q;
  assign restart   = restart_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: a behavioural model queues expected directions.
module tb_uart_cmd_decoder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_wr = 1'b0;
  logic [1:0] dir;
  logic       dir_valid;
  logic       dir_ready = 1'b0;
  logic       paused;
  logic       restart;
  logic [7:0] err_count;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];
  logic [1:0] m_last;
  logic [1:0] m_lastpop;
  logic       m_paused;
  logic       m_restart;
  logic [7:0] m_err;

  uart_cmd_decoder #(.FIFO_DEPTH(DEPTH), .UPPER_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_wr      (rx_wr),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .dir_ready  (dir_ready),
    .paused     (paused),
    .restart    (restart),
    .err_count  (err_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_data = 8'h77;
    rx_wr = 1'b1;
    dir_ready = 1'b0;
    @(negedge clk);
    rx_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_last = 2'b01;
    m_lastpop = 2'b01;
    m_paused = 1'b0;
    m_restart = 1'b0;
    m_err = 8'd0;
  endtask

  // Drives one cycle (byte if wr, pop if with_pop) and advances the model to match.
  task automatic cycle(input logic [7:0] b, input bit wr, input bit with_pop);
    logic [7:0] c;
    logic [1:0] d;
    logic [1:0] hd;
    bit isdir;
    if (with_pop) begin
      hd = exp_q.pop_front();
      checks++;
      if (dir_valid !== 1'b1 || dir !== hd) begin
        errors++;
        $display("FAIL pop_head: valid=%0b dir=%0d, required valid=1 dir=%0d", dir_valid, dir, hd);
      end
      m_lastpop = hd;
      dir_ready = 1'b1;
    end
    m_restart = 1'b0;
    if (wr) begin
      c = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
      isdir = 1'b1;
      d = 2'b00;
      case (c)
        8'h77: d = 2'b00;
        8'h64: d = 2'b01;
        8'h73: d = 2'b10;
        8'h61: d = 2'b11;
        default: isdir = 1'b0;
      endcase
      if (isdir) begin
        if (!m_paused && d != m_last) begin
          if (d == (m_last ^ 2'b10)) begin
            if (m_err != 8'hFF) m_err++;
          end else if (exp_q.size() >= DEPTH) begin
            if (m_err != 8'hFF) m_err++;
          end else begin
            exp_q.push_back(d);
            m_last = d;
          end
        end
      end else if (c == 8'h70) begin
        m_paused = !m_paused;
      end else if (c == 8'h72) begin
        exp_q.delete();
        m_paused = 1'b0;
        m_last = 2'b01;
        m_restart = 1'b1;
      end else begin
        if (m_err != 8'hFF) m_err++;
      end
    end
    rx_data = b;
    rx_wr = wr;
    @(negedge clk);
    rx_wr = 1'b0;
    dir_ready = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cycle(8'h00, 1'b0, 1'b1);
    checks++;
    if (dir_valid !== 1'b0 || dir !== m_lastpop || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: valid=%0b dir=%0d level=%0d, required valid=0 dir=%0d level=0",
               dir_valid, dir, fifo_level, m_lastpop);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dir !== 2'b01 || dir_valid !== 1'b0 || paused !== 1'b0 || restart !== 1'b0 ||
        err_count !== 8'd0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: dir=%0d valid=%0b paused=%0b restart=%0b err=%0d level=%0d, required 1 0 0 0 0 0",
               dir, dir_valid, paused, restart, err_count, fifo_level);
    end
  endtask

  task automatic test_single();
    do_reset();
    cycle(8'h77, 1'b1, 1'b0);
    checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b00 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL single_w: valid=%0b dir=%0d level=%0d, required 1 0 1", dir_valid, dir, fifo_level);
    end
    cycle(8'h00, 1'b0, 1'b0);
    checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b00) begin
      errors++;
      $display("FAIL hold_no_ready: valid=%0b dir=%0d, required 1 0", dir_valid, dir);
    end
    drain();
  endtask

  task automatic test_reversal();
    do_reset();
    cycle(8'h61, 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reversal_a: err=%0d level=%0d, required 1 0", err_count, fifo_level);
    end
    cycle(8'h64, 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL same_dir_d: err=%0d level=%0d, required 1 0", err_count, fifo_level);
    end
    cycle(8'h57, 1'b1, 1'b0);
    checks++;
    if (fifo_level !== 3'd1 || dir !== 2'b00 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL upper_W: level=%0d dir=%0d err=%0d, required 1 0 1", fifo_level, dir, err_count);
    end
    drain();
  endtask

  task automatic test_full();
    logic [7:0] seq [4];
    seq[0] = 8'h77; seq[1] = 8'h64; seq[2] = 8'h73; seq[3] = 8'h64;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(seq[i], 1'b1, 1'b0);
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_level: level=%0d, required 4", fifo_level);
    end
    cycle(8'h77, 1'b1, 1'b0);
    checks++;
    if (fifo_level !== 3'd4 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL overflow_drop: level=%0d err=%0d, required 4 1", fifo_level, err_count);
    end
    drain();
  endtask

  task automatic test_full_pop();
    logic [7:0] seq [4];
    seq[0] = 8'h77; seq[1] = 8'h64; seq[2] = 8'h73; seq[3] = 8'h64;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(seq[i], 1'b1, 1'b0);
    cycle(8'h77, 1'b1, 1'b1);
    checks++;
    if (fifo_level !== 3'd4 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d err=%0d, required 4 0", fifo_level, err_count);
    end
    drain();
  endtask

  task automatic test_pause();
    do_reset();
    cycle(8'h77, 1'b1, 1'b0);
    cycle(8'h64, 1'b1, 1'b0);
    cycle(8'h70, 1'b1, 1'b0);
    checks++;
    if (dir_valid !== 1'b0 || paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_on: valid=%0b paused=%0b, required 0 1", dir_valid, paused);
    end
    cycle(8'h73, 1'b1, 1'b0);
    dir_ready = 1'b1;
    @(negedge clk);
    dir_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd2 || err_count !== 8'd0 || dir_valid !== 1'b0) begin
      errors++;
      $display("FAIL paused_ignore: level=%0d err=%0d valid=%0b, required 2 0 0", fifo_level, err_count, dir_valid);
    end
    cycle(8'h70, 1'b1, 1'b0);
    checks++;
    if (dir_valid !== 1'b1 || dir !== 2'b00 || paused !== 1'b0) begin
      errors++;
      $display("FAIL unpause_head: valid=%0b dir=%0d paused=%0b, required 1 0 0", dir_valid, dir, paused);
    end
    drain();
  endtask

  task automatic test_restart();
    do_reset();
    cycle(8'h77, 1'b1, 1'b0);
    cycle(8'h64, 1'b1, 1'b0);
    cycle(8'h73, 1'b1, 1'b0);
    cycle(8'h70, 1'b1, 1'b0);
    cycle(8'h72, 1'b1, 1'b0);
    checks++;
    if (restart !== 1'b1 || fifo_level !== 3'd0 || paused !== 1'b0 || dir_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_pulse: restart=%0b level=%0d paused=%0b valid=%0b, required 1 0 0 0",
               restart, fifo_level, paused, dir_valid);
    end
    cycle(8'h61, 1'b1, 1'b0);
    checks++;
    if (restart !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL restart_once: restart=%0b err=%0d, required 0 1", restart, err_count);
    end
    for (int i = 0; i < 300; i++) cycle(8'hFF, 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd255 || err_count !== m_err) begin
      errors++;
      $display("FAIL err_saturate: err=%0d, required 255", err_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [9];
    int k;
    bit p;
    tbl[0] = 8'h77; tbl[1] = 8'h64; tbl[2] = 8'h73; tbl[3] = 8'h61; tbl[4] = 8'h53;
    tbl[5] = 8'h70; tbl[6] = 8'h72; tbl[7] = 8'h78; tbl[8] = 8'h41;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 11);
      p = (exp_q.size() > 0) && !m_paused && ($urandom_range(0, 1) == 1);
      if (k == 6 && $urandom_range(0, 3) != 0) k = 9;
      if (k >= 9) cycle(8'h00, 1'b0, p);
      else        cycle(tbl[k], 1'b1, p);
      checks++;
      if (fifo_level !== exp_q.size() || err_count !== m_err || paused !== m_paused ||
          restart !== m_restart) begin
        errors++;
        $display("FAIL b2b_state[%0d]: level=%0d err=%0d paused=%0b restart=%0b, required %0d %0d %0b %0b",
                 i, fifo_level, err_count, paused, restart, exp_q.size(), m_err, m_paused, m_restart);
      end
    end
    if (m_paused) cycle(8'h70, 1'b1, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reversal();
    test_full();
    test_full_pop();
    test_pause();
    test_restart();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
